// File: rtl/zero_cross_ctrl_if.sv
// zero_cross_ctrl_if
// Bundles the job handshake and the frame-buffer read port of zero_cross_ctrl.
//   start/base/len     : job request (controller input)
//   busy/done/zc_count : job status and result (controller output)
//   mem_rd/mem_addr    : buffer read strobe and address (controller output)
//   mem_data           : buffer read data, one cycle after mem_rd (controller input)
// slave  = controller side, master = requester/buffer side.
interface zero_cross_ctrl_if #(
  parameter int N  = 32,
  parameter int AW = 8,
  parameter int CW = 8
);
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] zc_count;

  modport slave  (input  start, base, len, mem_data,
                  output mem_rd, mem_addr, busy, done, zc_count);
  modport master (output start, base, len, mem_data,
                  input  mem_rd, mem_addr, busy, done, zc_count);
endinterface

// File: rtl/zero_cross_ctrl.sv
// zero_cross_ctrl
// Scans len float32 samples starting at base in a synchronous-read buffer and
// counts sign changes between adjacent samples (saturating at 2^CW-1).
// One read is issued per clock; a one-cycle done pulse reports completion.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-low reset
//   bus   : zero_cross_ctrl_if.slave (job handshake + buffer read port)
module zero_cross_ctrl #(
  parameter int N  = 32,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  zero_cross_ctrl_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mem_rd, r_cap_vld, r_done, r_prev_sign;
  logic [AW-1:0] r_mem_addr, r_base, r_len, r_rd_idx, r_cap_idx;
  logic [CW-1:0] r_zc;

  logic w_accept, w_long, w_rd_more, w_cap, w_last, w_sign;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_long    = (bus.len >= AW'(2));
  // one extra bit so rd_idx+1 cannot wrap before the compare
  assign w_rd_more = (({1'b0, r_rd_idx} + (AW+1)'(1)) < {1'b0, r_len});
  // r_cap_vld marks that mem_data now holds the word requested last cycle
  assign w_cap     = (r_state == S_RUN) && r_cap_vld;
  assign w_last    = w_cap && (r_cap_idx == (r_len - AW'(1)));
  assign w_sign    = bus.mem_data[N-1];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_long) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)             w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_cap_vld   <= 1'b0;
      r_done      <= 1'b0;
      r_prev_sign <= 1'b0;
      r_base      <= '0;
      r_len       <= '0;
      r_rd_idx    <= '0;
      r_cap_idx   <= '0;
      r_zc        <= '0;
    end else begin
      r_cap_vld <= r_mem_rd;
      r_done    <= 1'b0;
      if (w_accept) begin
        r_base      <= bus.base;
        r_len       <= bus.len;
        r_zc        <= '0;
        r_rd_idx    <= '0;
        r_cap_idx   <= '0;
        r_prev_sign <= 1'b0;
        if (w_long) begin
          r_mem_rd   <= 1'b1;
          r_mem_addr <= bus.base;
        end else begin
          // degenerate frame: nothing to compare, finish immediately
          r_done <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        if (w_rd_more) begin
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_base + r_rd_idx + AW'(1);
          r_rd_idx   <= r_rd_idx + AW'(1);
        end else begin
          r_mem_rd <= 1'b0;
        end
        if (w_cap) begin
          // first sample only seeds the reference sign
          if ((r_cap_idx != '0) && (w_sign != r_prev_sign) && (r_zc != '1))
            r_zc <= r_zc + CW'(1);
          r_prev_sign <= w_sign;
          r_cap_idx   <= r_cap_idx + AW'(1);
          if (w_last) r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;
  assign bus.zc_count = r_zc;

endmodule

// File: tb/tb_zero_cross_ctrl.sv
// Directed bench for zero_cross_ctrl: stimulus pushes expected addresses and
// results into queues; negedge monitors pop and compare when the DUT presents
// mem_rd or done. u0 uses CW=8, u1 uses CW=2 for saturation.
module tb_zero_cross_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zero_cross_ctrl_if #(.N(32), .AW(8), .CW(8)) b0 ();
  zero_cross_ctrl_if #(.N(32), .AW(8), .CW(2)) b1 ();

  zero_cross_ctrl #(.N(32), .AW(8), .CW(8)) u0 (.i_clk(clk), .i_rst(rst_n), .bus(b0.slave));
  zero_cross_ctrl #(.N(32), .AW(8), .CW(2)) u1 (.i_clk(clk), .i_rst(rst_n), .bus(b1.slave));

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (b0.mem_rd) b0.mem_data <= mem[b0.mem_addr];
    if (b1.mem_rd) b1.mem_data <= mem[b1.mem_addr];
  end

  typedef struct { int val; int cyc; } exp_t;
  exp_t aq0[$];
  exp_t dq0[$];
  exp_t dq1[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // address monitor (u0)
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b0.mem_rd) begin
      if (aq0.size() == 0) flag("addr0_unexpected");
      else begin
        e = aq0.pop_front();
        check("addr0", int'(b0.mem_addr), e.val);
        check("addr0_cyc", cyc, e.cyc);
      end
    end
  end

  // result monitors
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b0.done) begin
      if (dq0.size() == 0) flag("done0_unexpected");
      else begin
        e = dq0.pop_front();
        check("zc0", int'(b0.zc_count), e.val);
        check("done0_cyc", cyc, e.cyc);
        check("busy0_in_done", int'(b0.busy), 0);
      end
    end
    if (rst_n && b1.done) begin
      if (dq1.size() == 0) flag("done1_unexpected");
      else begin
        e = dq1.pop_front();
        check("zc1", int'(b1.zc_count), e.val);
        check("done1_cyc", cyc, e.cyc);
      end
    end
  end

  // Drive a start (call away from posedge); returns at E0+1.
  task automatic issue(input int sel, input int base, input int len, input int expc, input bit abort);
    int c0;
    exp_t e;
    if (sel == 0) begin b0.start = 1'b1; b0.base = 8'(base); b0.len = 8'(len); end
    else          begin b1.start = 1'b1; b1.base = 8'(base); b1.len = 8'(len); end
    @(posedge clk); #1;
    c0 = cyc;
    b0.start = 1'b0;
    b1.start = 1'b0;
    if (sel == 0 && len >= 2)
      for (int k = 0; k < len; k++)
        if (!abort || k < 2) begin
          e.val = (base + k) % 256; e.cyc = c0 + k; aq0.push_back(e);
        end
    if (!abort) begin
      e.val = expc;
      e.cyc = (len < 2) ? c0 : c0 + len + 1;
      if (sel == 0) dq0.push_back(e); else dq1.push_back(e);
    end
  endtask

  task automatic wait_done(input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && b0.done) || (sel == 1 && b1.done)) return;
    end
    flag("done_timeout");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h3F80_0000;
    b0.start = 1'b0; b0.base = '0; b0.len = '0; b0.mem_data = '0;
    b1.start = 1'b0; b1.base = '0; b1.len = '0; b1.mem_data = '0;

    // reset state
    #3;
    check("rst_mem_rd0", int'(b0.mem_rd), 0);
    check("rst_addr0",   int'(b0.mem_addr), 0);
    check("rst_busy0",   int'(b0.busy), 0);
    check("rst_done0",   int'(b0.done), 0);
    check("rst_zc0",     int'(b0.zc_count), 0);
    check("rst_mem_rd1", int'(b1.mem_rd), 0);
    check("rst_busy1",   int'(b1.busy), 0);
    check("rst_zc1",     int'(b1.zc_count), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // basic: +1.0, -2.0, -0.5, +3.0 -> 2
    mem[8'h10] = 32'h3F80_0000; mem[8'h11] = 32'hC000_0000;
    mem[8'h12] = 32'hBF00_0000; mem[8'h13] = 32'h4040_0000;
    issue(0, 8'h10, 4, 2, 1'b0);
    wait_done(0, 20);

    // len=1 and len=0: immediate done, count cleared, no reads, never busy
    @(negedge clk);
    issue(0, 8'h70, 1, 0, 1'b0);
    check("busy_len1", int'(b0.busy), 0);
    wait_done(0, 5);
    @(negedge clk);
    issue(0, 8'h70, 0, 0, 1'b0);
    check("busy_len0", int'(b0.busy), 0);
    wait_done(0, 5);

    // alternating +0.0 / -0.0 -> 5
    for (int k = 0; k < 6; k++) mem[8'h20 + k] = (k % 2 == 1) ? 32'h8000_0000 : 32'h0000_0000;
    @(negedge clk);
    issue(0, 8'h20, 6, 5, 1'b0);
    wait_done(0, 20);

    // start during RUN ignored; start in done cycle accepted
    mem[8'h30] = 32'h3F80_0000; mem[8'h31] = 32'h4000_0000; mem[8'h32] = 32'hBF80_0000;
    @(negedge clk);
    issue(0, 8'h10, 4, 2, 1'b0);
    @(negedge clk);
    b0.start = 1'b1; b0.base = 8'h40; b0.len = 8'd2;
    @(posedge clk); #1 b0.start = 1'b0;
    wait_done(0, 20);
    issue(0, 8'h30, 3, 1, 1'b0);
    wait_done(0, 20);

    // reset mid-job after E2: outputs clear asynchronously, no done
    @(negedge clk);
    issue(0, 8'h50, 8, 0, 1'b1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort_mem_rd", int'(b0.mem_rd), 0);
    check("abort_addr",   int'(b0.mem_addr), 0);
    check("abort_busy",   int'(b0.busy), 0);
    check("abort_done",   int'(b0.done), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // post-reset job with address wrap: FE(-) FF(+) 00(+) 01(-) -> 2
    mem[8'hFE] = 32'hBF80_0000; mem[8'hFF] = 32'h3F80_0000;
    mem[8'h00] = 32'h3F80_0000; mem[8'h01] = 32'hC040_0000;
    issue(0, 8'hFE, 4, 2, 1'b0);
    wait_done(0, 20);

    // CW=2, 7 crossings -> saturates at 3
    for (int k = 0; k < 8; k++) mem[8'h60 + k] = (k % 2 == 1) ? 32'h8000_0000 : 32'h3F80_0000;
    @(negedge clk);
    issue(1, 8'h60, 8, 3, 1'b0);
    wait_done(1, 20);

    repeat (3) @(negedge clk);
    check("aq0_empty", aq0.size(), 0);
    check("dq0_empty", dq0.size(), 0);
    check("dq1_empty", dq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
